ex_muldiv: RTL and testbench

//  Iterative multiply/divide unit in the EX stage; consumes operands and control driven out of the ID/EX pipeline register.

---
 rtl/ex_muldiv_if.sv | 15 +
 rtl/ex_muldiv.sv | 124 ++++++++++++
 tb/tb_ex_muldiv.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Handshake/bus between the ID/EX control and the iterative mul/div unit.
interface ex_muldiv_if #(parameter int WIDTH = 32);
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output en, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input en, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, owning the HI/LO registers.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             is_div, neg_q, neg_r, div0;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r;

    logic             md_req, signed_op, div_op;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign md_req    = bus.en && (bus.op inside {3'b001, 3'b010, 3'b011, 3'b100});
    assign signed_op = (bus.op == 3'b001) || (bus.op == 3'b011);
    assign div_op    = (bus.op == 3'b011) || (bus.op == 3'b100);
    assign a_abs     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign bus.busy = ~bus.flush & ((state == CALC) | ((state == IDLE) & md_req));
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Multiply step: acc_hi accumulates, multiplier bits shift out of acc_lo.
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

    // Divide step: remainder in acc_hi, dividend shifts out / quotient shifts into acc_lo.
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = ~div_diff[WIDTH];

    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    always_comb begin
        if (is_div) begin
            nxt_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign-corrected results of the final iteration, written at the completion edge.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod     = {nxt_hi, nxt_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = div0 ? '1 : (neg_q ? -nxt_lo : nxt_lo);
    assign rem_fix  = neg_r ? -nxt_hi : nxt_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (md_req && !bus.flush) begin
                        state  <= CALC;
                        count  <= '0;
                        acc_hi <= '0;
                        acc_lo <= div_op ? a_abs : b_abs;
                        opnd   <= div_op ? b_abs : a_abs;
                        is_div <= div_op;
                        neg_q  <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r  <= signed_op & bus.a[WIDTH-1];
                        div0   <= (bus.b == '0);
                    end else if (bus.en && !bus.flush && bus.op == 3'b101) begin
                        hi_r <= bus.a;
                    end else if (bus.en && !bus.flush && bus.op == 3'b110) begin
                        lo_r <= bus.a;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        count  <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            if (is_div) begin
                                hi_r <= rem_fix;
                                lo_r <= quo_fix;
                            end else begin
                                hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                                lo_r <= prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                end
                // The stalled instruction is still presented here; never restart from DONE.
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected {hi,lo}, a monitor pops on done.
module tb_ex_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(W)) bus ();
    ex_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", bus.hi, bus.lo);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", {bus.hi, bus.lo}, mon_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv);
        logic [63:0] prev;
        int cnt;
        prev = {bus.hi, bus.lo};
        cnt = 0;
        @(negedge clk);
        bus.en = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        exp_q.push_back(expv);
        #1;
        while (bus.busy && cnt < 100) begin
            cnt++;
            if (cnt == 2) begin
                bus.a = ~a;
                bus.b = b + 32'd3;
            end
            if (cnt == 5) chk("hold_calc", {bus.hi, bus.lo}, prev);
            @(negedge clk);
            #1;
        end
        chk("busy_cycles", 64'(cnt), 64'(W + 1));
        bus.a = a; bus.b = b;
        chk("done_state", {62'd0, bus.done, bus.busy}, 64'b10);
        @(negedge clk);
        bus.en = 1'b0; bus.op = 3'd0;
        #1;
        chk("no_restart", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic flush_at(input int calc_cycle);
        logic [63:0] prev;
        prev = {bus.hi, bus.lo};
        @(negedge clk);
        bus.en = 1'b1; bus.op = 3'd1; bus.a = 32'd77; bus.b = 32'd99;
        repeat (calc_cycle) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        bus.flush = 1'b0; bus.en = 1'b0; bus.op = 3'd0;
        #1;
        chk("flush_idle", {63'd0, bus.busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("flush_hold", {bus.hi, bus.lo}, prev);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] prev;

        rst = 1'b1;
        bus.en = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        #1;
        chk("reset_state", {bus.hi, bus.lo}, 64'd0);
        chk("reset_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_md(3'd1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1);
        run_md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        run_md(3'd3, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
        run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_md(3'd4, 32'h00001234, 32'd0,        64'h00001234_FFFFFFFF);
        run_md(3'd3, 32'hFFFFFF00, 32'd0,        64'hFFFFFF00_FFFFFFFF);

        // MTHI / MTLO: single cycle, no stall.
        prev = {bus.hi, bus.lo};
        @(negedge clk);
        bus.en = 1'b1; bus.op = 3'd5; bus.a = 32'hCAFE0000;
        #1;
        chk("mthi_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        bus.op = 3'd6; bus.a = 32'h0000BEEF;
        chk("mthi", {bus.hi, bus.lo}, {32'hCAFE0000, prev[31:0]});
        @(negedge clk);
        bus.en = 1'b0; bus.op = 3'd0;
        chk("mtlo", {bus.hi, bus.lo}, 64'hCAFE0000_0000BEEF);
        // en=0 with a write op must do nothing.
        bus.op = 3'd5; bus.a = 32'h11111111;
        @(negedge clk);
        bus.op = 3'd0;
        chk("en_low", {bus.hi, bus.lo}, 64'hCAFE0000_0000BEEF);

        flush_at(10);
        flush_at(32);
        run_md(3'd1, 32'd6, 32'hFFFFFFF9, 64'hFFFFFFFF_FFFFFFD6);

        // flush with a request in IDLE: no accept.
        @(negedge clk);
        bus.en = 1'b1; bus.op = 3'd2; bus.flush = 1'b1;
        #1;
        chk("flush_idle_req", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        bus.en = 1'b0; bus.op = 3'd0; bus.flush = 1'b0;
        #1;
        chk("flush_idle_noacc", {63'd0, bus.busy}, 64'd0);

        // Reset mid-divide.
        @(negedge clk);
        bus.en = 1'b1; bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd7;
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b1;
        bus.en = 1'b0; bus.op = 3'd0;
        #1;
        chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_mid_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_md(rop, ra, rb, model(rop, ra, rb));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
